// File: rtl/gate_io_pkg.sv
// Shared definitions for the gate block input front-end.
//   state_t                  : per-channel debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT  : stable-sample count for a ~board-rate switch
//   CNT_W_DEFAULT            : counter width wide enough for the default count
package gate_io_pkg;

  typedef enum logic [1:0] {
    S_LO = 2'b00,  // settled low
    W_HI = 2'b01,  // qualifying a low->high change
    S_HI = 2'b10,  // settled high
    W_LO = 2'b11   // qualifying a high->low change
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
  localparam int CNT_W_DEFAULT           = 20;

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-FF synchroniser followed by a debounce FSM.
// A new level is accepted only after DEBOUNCE_CYCLES consecutive identical
// synchronised samples; any disagreeing sample restarts qualification.
// Ports:
//   clk    in  : system clock, rising edge
//   rst_n  in  : synchronous reset, active-low
//   sw     in  : raw asynchronous switch
//   level  out : debounced level (registered)
//   rise   out : one-cycle pulse in the cycle level goes 0->1
//   fall   out : one-cycle pulse in the cycle level goes 1->0
// The FSM state and counter are plain named registers (state, cnt) so they
// can be observed hierarchically.
module debounce_channel
  import gate_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= S_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      // Straight two-flop chain; nothing may sit between s1 and s2.
      s1   <= sw;
      s2   <= s1;
      // Pulses default low so they last exactly one cycle.
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        S_LO: begin
          if (s2) begin
            state <= W_HI;
            cnt   <= CNT_ONE;  // this sample already counts as the first
          end else begin
            cnt <= '0;
          end
        end
        W_HI: begin
          if (!s2) begin
            state <= S_LO;  // glitch rejected, no pulse
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_HI;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HI: begin
          if (!s2) begin
            state <= W_LO;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        W_LO: begin
          if (s2) begin
            state <= S_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_LO;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          // Unreachable with a 2-bit encoding; recover to a known low state.
          state <= S_LO;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gate_input_conditioner.sv
// Front-end for the basic gate block: conditions two raw board switches into
// clean operand levels a/b with per-operand edge pulses and a combined
// any-change strobe.
// Ports:
//   clk            in  : system clock, rising edge
//   rst_n          in  : synchronous reset, active-low
//   sw_a, sw_b     in  : raw asynchronous switch inputs
//   a, b           out : debounced operand levels
//   a_rise, a_fall out : one-cycle edge pulses for a
//   b_rise, b_fall out : one-cycle edge pulses for b
//   change         out : OR of the four edge pulses, same cycle
module gate_input_conditioner
  import gate_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_a,
  input  logic sw_b,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall,
  output logic change
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_a),
    .level(a),
    .rise (a_rise),
    .fall (a_fall)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw_b),
    .level(b),
    .rise (b_rise),
    .fall (b_fall)
  );

  // Pulses are already registered, so change lines up with them exactly.
  assign change = a_rise | a_fall | b_rise | b_fall;

endmodule

// File: tb/tb_gate_input_conditioner.sv
module tb_gate_input_conditioner;
  import gate_io_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic sw_a;
  logic sw_b;
  logic a, b, a_rise, a_fall, b_rise, b_fall, change;

  always #5 clk = ~clk;

  gate_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_a  (sw_a),
    .sw_b  (sw_b),
    .a     (a),
    .b     (b),
    .a_rise(a_rise),
    .a_fall(a_fall),
    .b_rise(b_rise),
    .b_fall(b_fall),
    .change(change)
  );

  // ---------------- scoreboard ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Output bundle order: {a, b, a_rise, a_fall, b_rise, b_fall, change}
  function automatic logic [6:0] outs();
    return {a, b, a_rise, a_fall, b_rise, b_fall, change};
  endfunction

  // ---------------- driver ----------------
  // One active edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst_n;
    logic       sw_a;
    logic       sw_b;
    int         reps;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int fall_cnt, fall_edge, rise_cnt, rise_edge, b_rise_edge;
    int max_cnt;
    logic a_at8;
    logic bnc [8];

    rst_n = 1'b0;
    sw_a  = 1'b1;
    sw_b  = 1'b1;

    // Reset with both switches high, release: rise at 6th edge.
    vecs.push_back('{1'b0, 1'b1, 1'b1, 2, 7'b0000000});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 5, 7'b0000000});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1, 7'b1110101});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 3, 7'b1100000});
    // Walk 00, 01, 10, 11.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 5, 7'b1100000});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 7'b0001011});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3, 7'b0000000});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 5, 7'b0000000});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1, 7'b0100101});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 3, 7'b0100000});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 5, 7'b0100000});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1, 7'b1010011});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 3, 7'b1000000});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 5, 7'b1000000});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1, 7'b1100101});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 3, 7'b1100000});
    // Both fall, then both rise on the same edge.
    vecs.push_back('{1'b1, 1'b0, 1'b0, 5, 7'b1100000});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1, 7'b0001011});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 3, 7'b0000000});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 5, 7'b0000000});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1, 7'b1110101});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 3, 7'b1100000});

    for (int i = 0; i < vecs.size(); i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        rst_n = vecs[i].rst_n;
        sw_a  = vecs[i].sw_a;
        sw_b  = vecs[i].sw_b;
        step();
        check($sformatf("vec%0d.%0d", i, r), 32'(outs()), 32'(vecs[i].exp));
      end
    end

    // Bounce while a=1: exactly one fall, 6 edges after final 1->0 sample.
    bnc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fall_cnt = 0; fall_edge = 0; rise_cnt = 0; a_at8 = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      sw_a = (e <= 8) ? bnc[e-1] : 1'b0;
      step();
      if (a_fall) begin
        fall_cnt++;
        if (fall_edge == 0) fall_edge = e;
      end
      if (a_rise) rise_cnt++;
      if (e == 8) a_at8 = a;
    end
    check("bounce_fall_count", 32'(fall_cnt), 32'd1);
    check("bounce_fall_edge", 32'(fall_edge), 32'd9);
    check("bounce_no_rise", 32'(rise_cnt), 32'd0);
    check("bounce_a_before", 32'(a_at8), 32'd1);
    check("bounce_a_after", 32'(a), 32'd0);
    check("bounce_b_held", 32'(b), 32'd1);

    // Short pulse while a=0: cnt reaches its limit but is not accepted.
    rise_cnt = 0; max_cnt = 0;
    for (int e = 1; e <= 10; e++) begin
      sw_a = (e <= 3) ? 1'b1 : 1'b0;
      step();
      if (a_rise || a) rise_cnt++;
      if (int'(dut.u_chan_a.cnt) > max_cnt) max_cnt = int'(dut.u_chan_a.cnt);
    end
    check("glitch_no_rise", 32'(rise_cnt), 32'd0);
    check("glitch_max_cnt", 32'(max_cnt), 32'd3);
    check("glitch_cnt_zero", 32'(dut.u_chan_a.cnt), 32'd0);
    check("glitch_state", 32'(dut.u_chan_a.state), 32'(S_LO));

    // Reset mid-qualification at W_HI cnt=2.
    sw_a = 1'b1;
    for (int e = 1; e <= 4; e++) step();
    check("mid_state", 32'(dut.u_chan_a.state), 32'(W_HI));
    check("mid_cnt", 32'(dut.u_chan_a.cnt), 32'd2);
    rst_n = 1'b0;
    step();
    check("mid_rst_outs", 32'(outs()), 32'd0);
    check("mid_rst_state", 32'(dut.u_chan_a.state), 32'(S_LO));
    check("mid_rst_cnt", 32'(dut.u_chan_a.cnt), 32'd0);
    rst_n = 1'b1;
    rise_cnt = 0; rise_edge = 0; b_rise_edge = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (a_rise) begin
        rise_cnt++;
        if (rise_edge == 0) rise_edge = e;
      end
      if (b_rise && b_rise_edge == 0) b_rise_edge = e;
    end
    check("post_rst_rise_count", 32'(rise_cnt), 32'd1);
    check("post_rst_rise_edge", 32'(rise_edge), 32'd6);
    check("post_rst_b_rise_edge", 32'(b_rise_edge), 32'd6);
    check("post_rst_levels", 32'({a, b}), 32'd3);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
